// File: rtl/max7219_frame_seq.sv
// Frame sequencer feeding max7219_if: one command becomes G_NB_MATRIX words, farthest matrix first.
// Optional broadcast mode (i_bcast port) is enabled by defining MAX7219_FRAME_SEQ_BCAST_EN.
module max7219_frame_seq #(
    parameter int G_NB_MATRIX       = 8,
    parameter int G_MAX_HALF_PERIOD = 4,
    parameter int G_LOAD_DURATION   = 4,
    parameter int G_GAP             = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [3:0]               i_addr,
    input  logic [8*G_NB_MATRIX-1:0] i_data,
`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    input  logic                     i_bcast,
`endif
    output logic                     o_start,
    output logic                     o_en_load,
    output logic [15:0]              o_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int C_WORD  = 32 * G_MAX_HALF_PERIOD + G_LOAD_DURATION + G_GAP;
    localparam int C_CNT_W = $clog2(C_WORD);
    localparam int C_IDX_W = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
    // SEND is the first cycle of a word, so WAIT ends one count early to keep SEND-to-SEND at C_WORD.
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_WORD - 2);
    localparam logic [C_IDX_W-1:0] C_IDX_TOP  = C_IDX_W'(G_NB_MATRIX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state;
    logic [3:0]               addr_q;
    logic [8*G_NB_MATRIX-1:0] data_q;
    logic [C_IDX_W-1:0]       idx;
    logic [C_CNT_W-1:0]       cnt;
    logic [7:0]               sel_byte;
    logic [8*G_NB_MATRIX-1:0] capture_data;

    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < G_NB_MATRIX; k++) begin
            if (idx == C_IDX_W'(k)) begin
                sel_byte = data_q[8*k +: 8];
            end
        end
    end

`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    always_comb begin
        capture_data = i_bcast ? {G_NB_MATRIX{i_data[7:0]}} : i_data;
    end
`else
    always_comb begin
        capture_data = i_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            idx       <= '0;
            cnt       <= '0;
            o_start   <= 1'b0;
            o_en_load <= 1'b0;
            o_data    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_start <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q <= i_addr;
                        data_q <= capture_data;
                        idx    <= C_IDX_TOP;
                        o_busy <= 1'b1;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    o_data    <= {4'h0, addr_q, sel_byte};
                    o_en_load <= (idx == '0);
                    o_start   <= 1'b1;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == C_CNT_LAST) begin
                        if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            state <= S_SEND;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    o_done    <= 1'b1;
                    o_busy    <= 1'b0;
                    o_en_load <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_frame_seq.sv
// Scoreboard bench for max7219_frame_seq: a 4-matrix instance and a 1-matrix instance.
module tb_max7219_frame_seq;

  localparam int N4     = 4;
  localparam int C_WORD = 134;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0;
  logic [3:0]  addr4 = 4'h0;
  logic [31:0] data4 = 32'h0;
  logic        start1 = 1'b0;
  logic [3:0]  addr1 = 4'h0;
  logic [7:0]  data1 = 8'h0;
`ifdef MAX7219_FRAME_SEQ_BCAST_EN
  logic        bcast4 = 1'b0;
  logic        bcast1 = 1'b0;
`endif

  logic        o_start4, o_en_load4, o_busy4, o_done4;
  logic [15:0] o_data4;
  logic        o_start1, o_en_load1, o_busy1, o_done1;
  logic [15:0] o_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {expected cycle, en_load, data}
  logic [48:0] exp_q[$];
  logic [31:0] done_q[$];
  logic [48:0] exp1_q[$];
  logic [31:0] done1_q[$];

  max7219_frame_seq #(.G_NB_MATRIX(N4), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4), .G_GAP(2)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_addr(addr4), .i_data(data4),
`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    .i_bcast(bcast4),
`endif
    .o_start(o_start4), .o_en_load(o_en_load4), .o_data(o_data4), .o_busy(o_busy4), .o_done(o_done4)
  );

  max7219_frame_seq #(.G_NB_MATRIX(1), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4), .G_GAP(2)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_addr(addr1), .i_data(data1),
`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    .i_bcast(bcast1),
`endif
    .o_start(o_start1), .o_en_load(o_en_load1), .o_data(o_data1), .o_busy(o_busy1), .o_done(o_done1)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=present expected=none (cycle %0d)", name, cyc);
  endtask

  // monitor for the 4-matrix instance
  always @(negedge clk) begin
    logic [48:0] e;
    if (!rst) begin
      if (o_start4) begin
        if (exp_q.size() == 0) flag("unexpected_start4");
        else begin
          e = exp_q.pop_front();
          check("start4_cycle", cyc, e[48:17]);
          check("data4", {16'h0, o_data4}, {16'h0, e[15:0]});
          check("en_load4", {31'h0, o_en_load4}, {31'h0, e[16]});
          check("busy4_during_word", {31'h0, o_busy4}, 32'h1);
        end
      end
      if (o_done4) begin
        if (done_q.size() == 0) flag("unexpected_done4");
        else begin
          check("done4_cycle", cyc, done_q.pop_front());
          check("busy4_after_done", {31'h0, o_busy4}, 32'h0);
          check("en_load4_after_done", {31'h0, o_en_load4}, 32'h0);
        end
      end
    end
  end

  // monitor for the 1-matrix instance
  always @(negedge clk) begin
    logic [48:0] e;
    if (!rst) begin
      if (o_start1) begin
        if (exp1_q.size() == 0) flag("unexpected_start1");
        else begin
          e = exp1_q.pop_front();
          check("start1_cycle", cyc, e[48:17]);
          check("data1", {16'h0, o_data1}, {16'h0, e[15:0]});
          check("en_load1", {31'h0, o_en_load1}, {31'h0, e[16]});
        end
      end
      if (o_done1) begin
        if (done1_q.size() == 0) flag("unexpected_done1");
        else check("done1_cycle", cyc, done1_q.pop_front());
      end
    end
  end

  // driver: issue a command to the 4-matrix instance and push its expected words
  task automatic start_frame4(input logic [3:0] a, input logic [31:0] d, input logic bc);
    int n;
    logic [7:0] b;
    int idx;
    @(posedge clk); #1;
    addr4 = a;
    data4 = d;
`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    bcast4 = bc;
`endif
    start4 = 1'b1;
    n = cyc;
    for (int k = 0; k < N4; k++) begin
      idx = N4 - 1 - k;
      b = bc ? d[7:0] : d[8*idx +: 8];
      exp_q.push_back({32'(n + 2 + C_WORD * k), (idx == 0), 4'h0, a, b});
    end
    done_q.push_back(32'(n + N4 * C_WORD + 2));
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic pulse_start4(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr4 = a;
    data4 = d;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || exp1_q.size() != 0 || done1_q.size() != 0)
           && t < limit) begin
      @(posedge clk);
      t++;
    end
    check(name, (t < limit) ? 32'h0 : 32'h1, 32'h0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // T1: reset, then idle with no start
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("outputs_in_reset", {o_start4, o_en_load4, o_busy4, o_done4, o_data4}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("idle4_outputs", {o_start4, o_en_load4, o_busy4, o_done4, o_data4}, 32'h0);
      check("idle1_outputs", {o_start1, o_en_load1, o_busy1, o_done1, o_data1}, 32'h0);
    end

    // T2 + T3: full frame; second start and input changes 200 cycles in are ignored
    start_frame4(4'h1, 32'h44332211, 1'b0);
    repeat (198) @(posedge clk);
    pulse_start4(4'h7, 32'hDEADBEEF);
    wait_drained("frame_t2_timeout", 800);

    // T4: reset during word 2, then a fresh full frame
    start_frame4(4'h3, 32'hA1B2C3D4, 1'b0);
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check("outputs_after_midframe_reset", {o_start4, o_en_load4, o_busy4, o_done4, o_data4}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    check("idle_after_midframe_reset", {o_start4, o_en_load4, o_busy4, o_done4, o_data4}, 32'h0);
    start_frame4(4'h5, 32'h0F1E2D3C, 1'b0);
    wait_drained("frame_t4_timeout", 800);

`ifdef MAX7219_FRAME_SEQ_BCAST_EN
    // T5: broadcast byte 0 to every matrix
    start_frame4(4'hA, 32'hFFFFFF05, 1'b1);
    wait_drained("frame_t5_timeout", 800);
    bcast4 = 1'b0;
`endif

    // T6: single-matrix chain
    @(posedge clk); #1;
    addr1 = 4'hC;
    data1 = 8'h01;
    start1 = 1'b1;
    exp1_q.push_back({32'(cyc + 2), 1'b1, 16'h0C01});
    done1_q.push_back(32'(cyc + 136));
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_drained("frame_t6_timeout", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
